game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer.sv | 162 ++++++++++++++++
 tb/tb_game_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Endless-runner game sequencer: start/run/hit/over FSM, one scrolling obstacle,
// collision check and score. Define SPEED_RAMP_EN to speed up every RAMP_STEP points.
module game_sequencer #(
  parameter int SCREEN_W   = 640,
  parameter int GROUND_Y   = 400,
  parameter int OBS_W      = 20,
  parameter int OBS_H      = 40,
  parameter int BASE_SPEED = 4,
  parameter int HIT_FRAMES = 30,
  parameter int RAMP_STEP  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_n,
  input  logic        frame_tick,
  input  logic [9:0]  role_x,
  input  logic [9:0]  role_y,
  input  logic [9:0]  role_w,
  input  logic [9:0]  role_h,
  output logic        stop,
  output logic [9:0]  obs_x,
  output logic [9:0]  obs_y,
  output logic [9:0]  obs_w,
  output logic [9:0]  obs_h,
  output logic [13:0] score,
  output logic [1:0]  state,
  output logic        game_over
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HIT  = 2'd2,
    S_OVER = 2'd3
  } state_t;

  localparam int HW = (HIT_FRAMES < 2) ? 1 : $clog2(HIT_FRAMES + 1);
  localparam int RW = (RAMP_STEP < 2) ? 1 : $clog2(RAMP_STEP);

  localparam logic [9:0]    SCREEN_X  = 10'(SCREEN_W);
  localparam logic [9:0]    OBS_Y     = 10'(GROUND_Y - OBS_H);
  localparam logic [10:0]   OBS_W11   = 11'(OBS_W);
  localparam logic [10:0]   OBS_H11   = 11'(OBS_H);
  localparam logic [3:0]    BASE_SPD  = 4'(BASE_SPEED);
  localparam logic [HW-1:0] HIT_LAST  = HW'(HIT_FRAMES);
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_STEP - 1);
  localparam logic [13:0]   SCORE_MAX = 14'd9999;

  state_t        state_q, state_d;
  logic          stop_q, stop_d;
  logic          game_over_q, game_over_d;
  logic [9:0]    obs_x_q, obs_x_d;
  logic [13:0]   score_q, score_d;
  logic [3:0]    speed_q, speed_d;
  logic [HW-1:0] hit_cnt_q, hit_cnt_d;
  logic [RW-1:0] ramp_cnt_q, ramp_cnt_d;
  logic          start_prev_q;

  logic          start_edge;
  logic          collide;
  logic [HW-1:0] hit_inc;

  assign start_edge = start_prev_q & ~start_n;
  assign hit_inc    = hit_cnt_q + 1'b1;

  // Axis-aligned box overlap; 11-bit sums so right/bottom edges cannot wrap.
  assign collide = ({1'b0, role_x} < ({1'b0, obs_x_q} + OBS_W11)) &&
                   ({1'b0, obs_x_q} < ({1'b0, role_x} + {1'b0, role_w})) &&
                   ({1'b0, role_y} < ({1'b0, OBS_Y} + OBS_H11)) &&
                   ({1'b0, OBS_Y} < ({1'b0, role_y} + {1'b0, role_h}));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      stop_q       <= 1'b1;
      game_over_q  <= 1'b0;
      obs_x_q      <= SCREEN_X;
      score_q      <= '0;
      speed_q      <= BASE_SPD;
      hit_cnt_q    <= '0;
      ramp_cnt_q   <= '0;
      start_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      stop_q       <= stop_d;
      game_over_q  <= game_over_d;
      obs_x_q      <= obs_x_d;
      score_q      <= score_d;
      speed_q      <= speed_d;
      hit_cnt_q    <= hit_cnt_d;
      ramp_cnt_q   <= ramp_cnt_d;
      start_prev_q <= start_n;
    end
  end

  always_comb begin
    state_d    = state_q;
    obs_x_d    = obs_x_q;
    score_d    = score_q;
    speed_d    = speed_q;
    hit_cnt_d  = hit_cnt_q;
    ramp_cnt_d = ramp_cnt_q;
    // stop/game_over follow the current state, so they trail a transition by one clock
    stop_d      = (state_q != S_RUN);
    game_over_d = (state_q == S_OVER);

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_edge) begin
          state_d    = S_RUN;
          obs_x_d    = SCREEN_X;
          score_d    = '0;
          speed_d    = BASE_SPD;
          ramp_cnt_d = '0;
        end
      end
      S_RUN: begin
        if (frame_tick) begin
          if (collide) begin
            state_d   = S_HIT;
            hit_cnt_d = '0;
          end else if (obs_x_q >= {6'd0, speed_q}) begin
            obs_x_d = obs_x_q - {6'd0, speed_q};
          end else begin
            obs_x_d = SCREEN_X;
            if (score_q != SCORE_MAX) begin
              score_d = score_q + 14'd1;
              // ramp_cnt tracks score modulo RAMP_STEP; it is only consumed when ramping
              if (ramp_cnt_q == RAMP_LAST) begin
                ramp_cnt_d = '0;
`ifdef SPEED_RAMP_EN
                if (speed_q != 4'd15) speed_d = speed_q + 4'd1;
`else
                speed_d = speed_q;
`endif
              end else begin
                ramp_cnt_d = ramp_cnt_q + 1'b1;
              end
            end
          end
        end
      end
      S_HIT: begin
        if (frame_tick) begin
          hit_cnt_d = hit_inc;
          if (hit_inc == HIT_LAST) state_d = S_OVER;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign stop      = stop_q;
  assign game_over = game_over_q;
  assign obs_x     = obs_x_q;
  assign obs_y     = OBS_Y;
  assign obs_w     = 10'(OBS_W);
  assign obs_h     = 10'(OBS_H);
  assign score     = score_q;
  assign state     = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: start, scrolling/scoring, collision, hit freeze,
// game over/restart, speed step (SPEED_RAMP_EN aware) and asynchronous reset mid-hit.
module tb_game_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_n;
  logic        frame_tick;
  logic [9:0]  role_x, role_y, role_w, role_h;
  logic        stop;
  logic [9:0]  obs_x, obs_y, obs_w, obs_h;
  logic [13:0] score;
  logic [1:0]  state;
  logic        game_over;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  game_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start_n    (start_n),
    .frame_tick (frame_tick),
    .role_x     (role_x),
    .role_y     (role_y),
    .role_w     (role_w),
    .role_h     (role_h),
    .stop       (stop),
    .obs_x      (obs_x),
    .obs_y      (obs_y),
    .obs_w      (obs_w),
    .obs_h      (obs_h),
    .score      (score),
    .state      (state),
    .game_over  (game_over)
  );

  // Driver tasks: inputs change on the falling edge, outputs are read there too.
  task automatic do_tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic press_start();
    @(negedge clk) start_n = 1'b0;
    @(negedge clk) start_n = 1'b1;
  endtask

  task automatic role_far();
    role_x = 10'd10; role_y = 10'd0; role_w = 10'd40; role_h = 10'd43;
  endtask

  task automatic role_hit();
    role_x = 10'd10; role_y = 10'd357; role_w = 10'd40; role_h = 10'd43;
  endtask

  task automatic test_reset();
    rst = 1'b0; start_n = 1'b1; frame_tick = 1'b0;
    role_far();
    #12;
    tests_run++;
    if (state !== 2'd0 || stop !== 1'b1 || game_over !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: state=%0d stop=%0b game_over=%0b, want 0/1/0", state, stop, game_over);
    end
    tests_run++;
    if (obs_x !== 10'd640 || score !== 14'd0) begin
      tests_failed++;
      $display("FAIL reset_data: obs_x=%0d score=%0d, want 640/0", obs_x, score);
    end
    tests_run++;
    if (obs_y !== 10'd360 || obs_w !== 10'd20 || obs_h !== 10'd40) begin
      tests_failed++;
      $display("FAIL obs_const: y=%0d w=%0d h=%0d, want 360/20/40", obs_y, obs_w, obs_h);
    end
    @(negedge clk) rst = 1'b1;
    repeat (3) do_tick();
    tests_run++;
    if (state !== 2'd0 || obs_x !== 10'd640 || stop !== 1'b1) begin
      tests_failed++;
      $display("FAIL idle_hold: state=%0d obs_x=%0d stop=%0b, want 0/640/1", state, obs_x, stop);
    end
  endtask

  task automatic test_start();
    press_start();
    tests_run++;
    if (state !== 2'd1 || obs_x !== 10'd640 || score !== 14'd0) begin
      tests_failed++;
      $display("FAIL start: state=%0d obs_x=%0d score=%0d, want 1/640/0", state, obs_x, score);
    end
    @(negedge clk);
    tests_run++;
    if (stop !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_stop: stop=%0b, want 0", stop);
    end
  endtask

  task automatic test_pass();
    role_far();
    repeat (160) do_tick();
    tests_run++;
    if (obs_x !== 10'd0 || score !== 14'd0) begin
      tests_failed++;
      $display("FAIL pass_edge: obs_x=%0d score=%0d, want 0/0", obs_x, score);
    end
    do_tick();
    tests_run++;
    if (obs_x !== 10'd640 || score !== 14'd1 || state !== 2'd1) begin
      tests_failed++;
      $display("FAIL pass_wrap: obs_x=%0d score=%0d state=%0d, want 640/1/1", obs_x, score, state);
    end
  endtask

  task automatic test_start_ignored();
    repeat (5) do_tick();
    press_start();
    tests_run++;
    if (state !== 2'd1 || obs_x !== 10'd620 || score !== 14'd1) begin
      tests_failed++;
      $display("FAIL start_in_run: state=%0d obs_x=%0d score=%0d, want 1/620/1", state, obs_x, score);
    end
  endtask

  task automatic test_collision();
    int n = 0;
    role_hit();
    while (state == 2'd1 && n < 200) begin
      do_tick();
      n++;
    end
    // 620 -> 48 takes 143 steps of 4, the 144th tick sees the overlap
    tests_run++;
    if (n !== 144 || state !== 2'd2) begin
      tests_failed++;
      $display("FAIL hit_latency: ticks=%0d state=%0d, want 144/2", n, state);
    end
    tests_run++;
    if (obs_x !== 10'd48 || score !== 14'd1) begin
      tests_failed++;
      $display("FAIL hit_freeze: obs_x=%0d score=%0d, want 48/1", obs_x, score);
    end
    @(negedge clk);
    tests_run++;
    if (stop !== 1'b1) begin
      tests_failed++;
      $display("FAIL hit_stop: stop=%0b, want 1", stop);
    end
  endtask

  task automatic test_hit_to_over();
    role_far();
    repeat (29) do_tick();
    tests_run++;
    if (state !== 2'd2 || obs_x !== 10'd48 || score !== 14'd1) begin
      tests_failed++;
      $display("FAIL hit_29: state=%0d obs_x=%0d score=%0d, want 2/48/1", state, obs_x, score);
    end
    press_start();
    tests_run++;
    if (state !== 2'd2) begin
      tests_failed++;
      $display("FAIL start_in_hit: state=%0d, want 2", state);
    end
    do_tick();
    tests_run++;
    if (state !== 2'd3) begin
      tests_failed++;
      $display("FAIL hit_30: state=%0d, want 3", state);
    end
    @(negedge clk);
    tests_run++;
    if (game_over !== 1'b1 || stop !== 1'b1) begin
      tests_failed++;
      $display("FAIL over_flags: game_over=%0b stop=%0b, want 1/1", game_over, stop);
    end
    press_start();
    tests_run++;
    if (state !== 2'd1 || score !== 14'd0 || obs_x !== 10'd640) begin
      tests_failed++;
      $display("FAIL restart: state=%0d score=%0d obs_x=%0d, want 1/0/640", state, score, obs_x);
    end
    @(negedge clk);
    tests_run++;
    if (game_over !== 1'b0 || stop !== 1'b0) begin
      tests_failed++;
      $display("FAIL restart_flags: game_over=%0b stop=%0b, want 0/0", game_over, stop);
    end
  endtask

  task automatic test_speed_ramp();
    logic [9:0] exp1, exp2;
`ifdef SPEED_RAMP_EN
    exp1 = 10'd635; exp2 = 10'd630;
`else
    exp1 = 10'd636; exp2 = 10'd632;
`endif
    repeat (10) repeat (161) do_tick();
    tests_run++;
    if (score !== 14'd10 || obs_x !== 10'd640) begin
      tests_failed++;
      $display("FAIL ten_passes: score=%0d obs_x=%0d, want 10/640", score, obs_x);
    end
    do_tick();
    tests_run++;
    if (obs_x !== exp1) begin
      tests_failed++;
      $display("FAIL speed_step1: obs_x=%0d, want %0d", obs_x, exp1);
    end
    do_tick();
    tests_run++;
    if (obs_x !== exp2) begin
      tests_failed++;
      $display("FAIL speed_step2: obs_x=%0d, want %0d", obs_x, exp2);
    end
  endtask

  task automatic test_reset_mid_hit();
    int n = 0;
    logic [9:0] exp_x;
`ifdef SPEED_RAMP_EN
    exp_x = 10'd45;
`else
    exp_x = 10'd48;
`endif
    role_hit();
    while (state == 2'd1 && n < 200) begin
      do_tick();
      n++;
    end
    role_far();
    tests_run++;
    if (state !== 2'd2 || obs_x !== exp_x || score !== 14'd10) begin
      tests_failed++;
      $display("FAIL hit2: state=%0d obs_x=%0d score=%0d, want 2/%0d/10", state, obs_x, score, exp_x);
    end
    repeat (15) do_tick();
    tests_run++;
    if (state !== 2'd2) begin
      tests_failed++;
      $display("FAIL hit_15: state=%0d, want 2", state);
    end
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if (state !== 2'd0 || stop !== 1'b1 || score !== 14'd0 || obs_x !== 10'd640 || game_over !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: state=%0d stop=%0b score=%0d obs_x=%0d go=%0b, want 0/1/0/640/0",
               state, stop, score, obs_x, game_over);
    end
    @(negedge clk) begin frame_tick = 1'b1; start_n = 1'b0; end
    repeat (3) @(negedge clk);
    tests_run++;
    if (state !== 2'd0 || obs_x !== 10'd640) begin
      tests_failed++;
      $display("FAIL reset_hold: state=%0d obs_x=%0d, want 0/640", state, obs_x);
    end
    frame_tick = 1'b0; start_n = 1'b1;
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (state !== 2'd0) begin
      tests_failed++;
      $display("FAIL post_reset: state=%0d, want 0", state);
    end
    press_start();
    tests_run++;
    if (state !== 2'd1 || obs_x !== 10'd640) begin
      tests_failed++;
      $display("FAIL start_after_reset: state=%0d obs_x=%0d, want 1/640", state, obs_x);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_pass();
    test_start_ignored();
    test_collision();
    test_hit_to_over();
    test_speed_ramp();
    test_reset_mid_hit();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
